// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory pipeline stage: opcode encoding,
// register-write decode and FSM state encoding.
package memory_stage_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_SUB    = 4'h1,
    OP_ADD    = 4'h2,
    OP_ADDI   = 4'h3,
    OP_SHLLI  = 4'h4,
    OP_SHRLI  = 4'h5,
    OP_JUMP   = 4'h6,
    OP_JUMPL  = 4'h7,
    OP_JUMPG  = 4'h8,
    OP_JUMPE  = 4'h9,
    OP_JUMPNE = 4'hA,
    OP_CMP    = 4'hB,
    OP_LOAD   = 4'hC,
    OP_LOADI  = 4'hD,
    OP_STORE  = 4'hE,
    OP_MOV    = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // LOAD is excluded: it only writes once the memory access completes.
  function automatic logic writes_reg(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOADI, OP_MOV:
        writes_reg = 1'b1;
      default:
        writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_timeout.sv
// Access-timeout counter: synchronous clear/load, count enable and a
// terminal-count flag when the count reaches TIMEOUT_CYCLES-1.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: non-memory ops pass through to write-back in one
// cycle; LOAD/STORE run a req/ack transaction with stall and timeout abort.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [4:0]        dest_index_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_dest_index,
  output logic              wb_write_en,
  output logic [4:0]        control_out,
  output logic              mem_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e           state, state_next;
  logic [3:0]       op;
  logic             is_mem_op;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_terminal;
  logic [CNT_W-1:0] cnt_value;
  logic [4:0]       cap_control;
  logic [4:0]       cap_dest;

  assign op        = control_in[3:0];
  assign is_mem_op = (op == OP_LOAD) || (op == OP_STORE);

  mem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (1'b0),
    .load_value ('0),
    .count_en   (cnt_en),
    .count      (cnt_value),
    .terminal   (cnt_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ack in the same cycle as terminal count wins over the timeout.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem_op) begin
          stall      = 1'b1;
          cnt_clear  = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || cnt_terminal) begin
          state_next = ST_IDLE;
        end else begin
          stall  = 1'b1;
          cnt_en = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wb_data       <= '0;
      wb_dest_index <= '0;
      wb_write_en   <= 1'b0;
      control_out   <= '0;
      mem_error     <= 1'b0;
      cap_control   <= '0;
      cap_dest      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem_op) begin
            mem_req     <= 1'b1;
            mem_we      <= (op == OP_STORE);
            mem_addr    <= result_in[ADDR_W-1:0];
            mem_wdata   <= store_data_in;
            cap_control <= control_in;
            cap_dest    <= dest_index_in;
            wb_write_en <= 1'b0;
            control_out <= '0;
          end else begin
            wb_data       <= result_in;
            wb_dest_index <= dest_index_in;
            wb_write_en   <= writes_reg(op);
            control_out   <= control_in;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            control_out   <= cap_control;
            wb_dest_index <= cap_dest;
            if (cap_control[3:0] == OP_LOAD) begin
              wb_data     <= mem_rdata;
              wb_write_en <= 1'b1;
            end else begin
              wb_write_en <= 1'b0;
            end
          end else if (cnt_terminal) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_error   <= 1'b1;
            wb_write_en <= 1'b0;
            control_out <= '0;
          end else begin
            wb_write_en <= 1'b0;
            control_out <= '0;
          end
        end
        default: begin
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
          wb_write_en <= 1'b0;
          control_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT_CYCLES = 4).
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic [4:0]  control_in;
  logic [15:0] result_in;
  logic [15:0] store_data_in;
  logic [4:0]  dest_index_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] wb_data;
  logic [4:0]  wb_dest_index;
  logic        wb_write_en;
  logic [4:0]  control_out;
  logic        mem_error;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(
    .DATA_W         (16),
    .ADDR_W         (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .control_in    (control_in),
    .result_in     (result_in),
    .store_data_in (store_data_in),
    .dest_index_in (dest_index_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .wb_data       (wb_data),
    .wb_dest_index (wb_dest_index),
    .wb_write_en   (wb_write_en),
    .control_out   (control_out),
    .mem_error     (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [15:0] res,
                       input logic [15:0] sdata, input logic [4:0] dest);
    control_in    = ctrl;
    result_in     = res;
    store_data_in = sdata;
    dest_index_in = dest;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(5'h00, 16'h0, 16'h0, 5'd0);
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_we", wb_write_en, 0);
    check("rst_ctrl_out", control_out, 0);
    check("rst_mem_error", mem_error, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;

    // ADD passes through with one-cycle latency
    drive(5'h02, 16'h1234, 16'h0, 5'd5);
    check("add_stall", stall, 0);
    step();
    check("add_wb_data", wb_data, 16'h1234);
    check("add_wb_dest", wb_dest_index, 5);
    check("add_wb_we", wb_write_en, 1);
    check("add_ctrl_out", control_out, 5'h02);

    // LOAD with zero-wait ack
    drive(5'h0C, 16'h0040, 16'h0, 5'd3);
    check("ld_issue_stall", stall, 1);
    check("ld_issue_req", mem_req, 0);
    step();
    check("ld_req", mem_req, 1);
    check("ld_we", mem_we, 0);
    check("ld_addr", mem_addr, 16'h0040);
    check("ld_bubble_we", wb_write_en, 0);
    check("ld_bubble_ctrl", control_out, 0);
    check("ld_access_stall", stall, 1);
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    check("ld_ack_stall", stall, 0);
    step();
    mem_ack = 1'b0;
    check("ld_req_drop", mem_req, 0);
    check("ld_wb_data", wb_data, 16'hBEEF);
    check("ld_wb_dest", wb_dest_index, 3);
    check("ld_wb_we", wb_write_en, 1);
    check("ld_ctrl_out", control_out, 5'h0C);

    // STORE acked after 3 wait cycles (ack coincides with terminal count)
    drive(5'h0E, 16'h0010, 16'h00AA, 5'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("st_req", mem_req, 1);
      check("st_we", mem_we, 1);
      check("st_addr", mem_addr, 16'h0010);
      check("st_wdata", mem_wdata, 16'h00AA);
      check("st_bubble_we", wb_write_en, 0);
      if (i < 3) begin
        check("st_wait_stall", stall, 1);
      end else begin
        mem_ack = 1'b1;
        #1;
        check("st_ack_stall", stall, 0);
      end
      step();
    end
    mem_ack = 1'b0;
    drive(5'h00, 16'h0, 16'h0, 5'd0);
    check("st_req_drop", mem_req, 0);
    check("st_wb_we", wb_write_en, 0);
    check("st_ctrl_out", control_out, 5'h0E);
    check("st_no_error", mem_error, 0);

    // LOAD that never gets an ack times out after 4 ACCESS cycles
    drive(5'h0C, 16'h0080, 16'h0, 5'd7);
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_req", mem_req, 1);
      check("to_stall", stall, (i < 3) ? 1 : 0);
      check("to_no_error_yet", mem_error, 0);
      step();
    end
    check("to_req_drop", mem_req, 0);
    check("to_error", mem_error, 1);
    check("to_wb_we", wb_write_en, 0);
    check("to_ctrl_out", control_out, 0);
    drive(5'h02, 16'h0055, 16'h0, 5'd2);
    check("to_add_stall", stall, 0);
    step();
    check("to_add_wb_data", wb_data, 16'h0055);
    check("to_add_wb_we", wb_write_en, 1);
    check("to_error_sticky", mem_error, 1);

    // Reset during ACCESS, then a late ack
    drive(5'h0C, 16'h0020, 16'h0, 5'd4);
    step();
    check("rs_req", mem_req, 1);
    reset = 1'b1;
    step();
    check("rs_req_drop", mem_req, 0);
    check("rs_error_clr", mem_error, 0);
    check("rs_wb_we", wb_write_en, 0);
    check("rs_ctrl_out", control_out, 0);
    check("rs_addr", mem_addr, 0);
    check("rs_wb_data", wb_data, 0);
    reset = 1'b0;
    drive(5'h00, 16'h0, 16'h0, 5'd0);
    mem_ack = 1'b1;
    mem_rdata = 16'h1111;
    step();
    mem_ack = 1'b0;
    check("rs_late_ack_we", wb_write_en, 0);
    check("rs_late_ack_req", mem_req, 0);
    check("rs_late_ack_data", wb_data, 0);

    // CMP, STORE, MOV sequence
    drive(5'h0B, 16'h0007, 16'h0, 5'd1);
    check("cmp_stall", stall, 0);
    step();
    check("cmp_wb_we", wb_write_en, 0);
    check("cmp_ctrl_out", control_out, 5'h0B);
    drive(5'h0E, 16'h0030, 16'h0009, 5'd0);
    step();
    check("seq_st_bubble_we", wb_write_en, 0);
    check("seq_st_bubble_ctrl", control_out, 0);
    check("seq_st_wdata", mem_wdata, 16'h0009);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("seq_st_wb_we", wb_write_en, 0);
    check("seq_st_ctrl", control_out, 5'h0E);
    drive(5'h0F, 16'h0009, 16'h0, 5'd6);
    check("mov_stall", stall, 0);
    step();
    check("mov_wb_data", wb_data, 16'h0009);
    check("mov_wb_dest", wb_dest_index, 6);
    check("mov_wb_we", wb_write_en, 1);
    check("mov_ctrl_out", control_out, 5'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
